// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one signed 32x32 Wallace multiplier between
// NUM_REQ requesters through a 2-stage valid/ready pipeline.

module wallace (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    logic [63:0] row [33];
    logic [63:0] nxt [33];
    logic [63:0] ax;
    int n;
    int m;

    always_comb begin
        ax = {{32{a[31]}}, a};
        for (int i = 0; i < 31; i++) begin
            row[i] = b[i] ? (ax << i) : '0;
        end
        // MSB of b has negative weight: ~x + 1, with the +1 as its own row
        row[31] = b[31] ? ~(ax << 31) : '0;
        row[32] = {63'd0, b[31]};
        n = 33;
        for (int l = 0; l < 8; l++) begin
            m = 0;
            for (int k = 0; k < 33; k++) begin
                nxt[k] = '0;
            end
            for (int k = 0; k < 11; k++) begin
                if (3 * k + 2 < n) begin
                    nxt[m] = row[3*k] ^ row[3*k+1] ^ row[3*k+2];
                    nxt[m+1] = ((row[3*k] & row[3*k+1]) |
                                (row[3*k] & row[3*k+2]) |
                                (row[3*k+1] & row[3*k+2])) << 1;
                    m = m + 2;
                end
            end
            for (int k = 0; k < 33; k++) begin
                if (k >= (n / 3) * 3 && k < n) begin
                    nxt[m] = row[k];
                    m = m + 1;
                end
            end
            row = nxt;
            n = m;
        end
        p = row[0] + row[1];
    end
endmodule

module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [63:0]             rsp_data,
    output logic                    busy
);
    logic            s1_valid;
    logic [ID_W-1:0] s1_id;
    logic [31:0]     s1_a;
    logic [31:0]     s1_b;
    logic            s2_valid;
    logic [ID_W-1:0] s2_id;
    logic [63:0]     s2_p;
    logic [ID_W-1:0] rr_ptr;
    logic [63:0]     prod;
    logic            s1_adv;
    logic            s2_adv;
    logic            gnt_any;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] ptr_nxt;
    logic            accept;
    int              idx;

    wallace u_wallace (
        .a (s1_a),
        .b (s1_b),
        .p (prod)
    );

    assign s2_adv = !s2_valid || rsp_ready[s2_id];
    assign s1_adv = !s1_valid || s2_adv;
    assign accept = s1_adv && gnt_any;

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
    end

    // explicit wrap keeps non-power-of-2 NUM_REQ in range
    assign ptr_nxt = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (rst_n && accept) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (s2_valid) begin
            rsp_valid[s2_id] = 1'b1;
        end
    end

    assign rsp_data = s2_p;
    assign busy     = s1_valid || s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            rr_ptr   <= '0;
        end else if (s1_adv) begin
            s1_valid <= gnt_any;
            if (gnt_any) begin
                s1_id  <= gnt_id;
                s1_a   <= req_a[32*gnt_id +: 32];
                s1_b   <= req_b[32*gnt_id +: 32];
                rr_ptr <= ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_p     <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            s2_p     <= s1_valid ? prod : '0;
        end
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: in-order queue model of the shared
// multiplier, directed scenarios plus a randomized phase.

module tb_mul_share_arbiter;
    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [63:0]  rsp_data;
    logic         busy;

    logic [2:0]   v3;
    logic [2:0]   rd3;
    logic [95:0]  a3;
    logic [95:0]  b3;
    logic [2:0]   rv3;
    logic [2:0]   rr3;
    logic [63:0]  d3;
    logic         busy3;

    mul_share_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    mul_share_arbiter #(.NUM_REQ(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (v3),
        .req_ready (rd3),
        .req_a     (a3),
        .req_b     (b3),
        .rsp_valid (rv3),
        .rsp_ready (rr3),
        .rsp_data  (d3),
        .busy      (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [63:0] p;
        bit          shown;
    } ent_t;

    ent_t        q[$];
    logic [63:0] seen[$];
    int          ptr;
    int          ptr3;
    int          acc_id;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mul(input logic [31:0] a,
                                        input logic [31:0] b);
        longint x;
        longint y;
        x = longint'({{32{a[31]}}, a});
        y = longint'({{32{b[31]}}, b});
        return 64'(x * y);
    endfunction

    task automatic step();
        logic [3:0] er;
        logic [3:0] ev;
        bit         can;
        int         g;
        ent_t       e;
        #1;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && req_valid[(ptr + k) % 4]) g = (ptr + k) % 4;
        end
        can = (q.size() < 2) || (q[0].shown && rsp_ready[q[0].id]);
        er = '0;
        if (can && g >= 0) er[g] = 1'b1;
        ev = '0;
        if (q.size() > 0 && q[0].shown) ev[q[0].id] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        if (ev != 4'd0) begin
            chk("rsp_data", rsp_data, q[0].p);
            seen.push_back(rsp_data);
        end
        chk("busy", 64'(busy), 64'(q.size() > 0));
        acc_id = (er != 4'd0) ? g : -1;
        @(posedge clk);
        if (q.size() > 0 && q[0].shown && rsp_ready[q[0].id]) begin
            void'(q.pop_front());
        end
        if (q.size() > 0 && !q[0].shown) begin
            e = q[0];
            e.shown = 1'b1;
            q[0] = e;
        end
        if (acc_id >= 0) begin
            e.id = acc_id;
            e.p = mul(req_a[32*acc_id +: 32], req_b[32*acc_id +: 32]);
            e.shown = 1'b0;
            q.push_back(e);
            ptr = (acc_id + 1) % 4;
        end
        @(negedge clk);
    endtask

    task automatic step3();
        logic [2:0] er;
        int         g;
        #1;
        g = -1;
        for (int k = 0; k < 3; k++) begin
            if (g < 0 && v3[(ptr3 + k) % 3]) g = (ptr3 + k) % 3;
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("rr3_ready", 64'(rd3), 64'(er));
        chk("rr3_ptr", 64'(dut3.rr_ptr), 64'(ptr3));
        @(posedge clk);
        if (g >= 0) ptr3 = (g + 1) % 3;
        @(negedge clk);
    endtask

    logic [31:0] ca [4];
    logic [31:0] cb [4];
    logic [63:0] ce [4];
    int          nacc;

    initial begin
        total = 0;
        bad = 0;
        ptr = 0;
        ptr3 = 0;
        acc_id = -1;
        rst_n = 1'b0;
        req_valid = 4'hF;
        req_a = '0;
        req_b = '0;
        rsp_ready = 4'hF;
        v3 = 3'b111;
        a3 = '0;
        b3 = '0;
        rr3 = 3'b111;
        ca[0] = -32'sd7;        cb[0] = 32'd6;
        ce[0] = 64'hFFFF_FFFF_FFFF_FFD6;
        ca[1] = 32'h8000_0000;  cb[1] = 32'h8000_0000;
        ce[1] = 64'h4000_0000_0000_0000;
        ca[2] = 32'hFFFF_FFFF;  cb[2] = 32'hFFFF_FFFF;
        ce[2] = 64'h1;
        ca[3] = 32'h7FFF_FFFF;  cb[3] = 32'h8000_0000;
        ce[3] = 64'hC000_0000_8000_0000;

        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready3", 64'(rd3), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v3 = '0;

        // single operation
        req_valid = 4'b0001;
        req_a[31:0] = 32'd3;
        req_b[31:0] = 32'd5;
        step();
        req_valid = 4'b0000;
        step();
        step();
        chk("single_cnt", 64'(seen.size()), 64'd1);
        if (seen.size() > 0) chk("single_data", seen.pop_front(), 64'hF);
        step();
        chk("single_busy", 64'(busy), 64'd0);

        // signed corners, back to back
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0001;
            req_a[31:0] = ca[i];
            req_b[31:0] = cb[i];
            step();
        end
        req_valid = 4'b0000;
        for (int i = 0; i < 3; i++) step();
        chk("corner_cnt", 64'(seen.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) chk("corner_data", seen[i], ce[i]);
        end

        // backpressure
        rsp_ready = 4'b0000;
        req_valid = 4'b0110;
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            req_a[63:32] = $urandom;
            req_b[63:32] = $urandom;
            req_a[95:64] = $urandom;
            req_b[95:64] = $urandom;
            step();
            if (acc_id >= 0) nacc++;
        end
        chk("bp_accepts", 64'(nacc), 64'd2);
        rsp_ready = 4'hF;
        for (int i = 0; i < 4; i++) step();
        req_valid = 4'b0000;
        for (int i = 0; i < 3; i++) step();

        // reset with both stages full
        rsp_ready = 4'b0000;
        req_valid = 4'b0001;
        req_a[31:0] = 32'd11;
        req_b[31:0] = 32'd13;
        for (int i = 0; i < 3; i++) step();
        req_valid = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rsp_data", rsp_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        ptr = 0;

        // round-robin fairness from requester 0
        rsp_ready = 4'hF;
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < 4; r++) begin
                req_a[32*r +: 32] = $urandom;
                req_b[32*r +: 32] = $urandom;
            end
            step();
            chk("rr_order", 64'(acc_id), 64'(i % 4));
        end
        req_valid = 4'b0000;
        for (int i = 0; i < 3; i++) step();

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            req_valid = 4'($urandom);
            for (int r = 0; r < 4; r++) begin
                req_a[32*r +: 32] = $urandom;
                req_b[32*r +: 32] = $urandom;
            end
            rsp_ready = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            step();
        end
        req_valid = 4'b0000;
        rsp_ready = 4'hF;
        for (int i = 0; i < 4; i++) step();

        // pointer wrap on the 3-requester instance
        v3 = 3'b100;
        step3();
        v3 = 3'b001;
        step3();
        v3 = 3'b101;
        for (int i = 0; i < 6; i++) step3();
        v3 = 3'b000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
